// File: rtl/calendar_display_scan.sv
// calendar_display_scan: time-multiplexes the calendar's twelve BCD digits onto a
// 4-digit common-anode 7-segment display, with button-stepped or auto-rotating pages.
module calendar_display_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int PAGE_HOLD = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sec1,
    input  logic [3:0] sec0,
    input  logic [3:0] min1,
    input  logic [3:0] min0,
    input  logic [3:0] hour1,
    input  logic [3:0] hour0,
    input  logic [3:0] day1,
    input  logic [3:0] day0,
    input  logic [3:0] month1,
    input  logic [3:0] month0,
    input  logic [3:0] year1,
    input  logic [3:0] year0,
    input  logic       page_btn,
    input  logic       auto_en,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic [1:0] page
);

    localparam int PW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {PG_HM = 2'd0, PG_MS = 2'd1, PG_MD = 2'd2, PG_YR = 2'd3} page_t;

    typedef struct packed {
        logic [3:0] sec1, sec0, min1, min0, hour1, hour0;
        logic [3:0] day1, day0, month1, month0, year1, year0;
    } digits_t;

    logic [PW-1:0] presc;
    logic          scan_tick;
    logic [1:0]    idx;
    digits_t       live, snap;
    page_t         snap_page;
    page_t         state, state_next;
    logic [3:0]    hold_cnt;
    logic          btn_d, sec_valid, btn_edge, sec_tick, advance;
    logic [3:0]    sec0_d;
    logic [3:0]    slot_digit;
    logic          slot_dp;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign live = {sec1, sec0, min1, min0, hour1, hour0, day1, day0, month1, month0, year1, year0};
    assign scan_tick = (presc == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            presc <= '0;
        else if (scan_tick) presc <= '0;
        else                presc <= presc + PW'(1);
    end

    // idx names the slot driven at the next scan_tick; slot 3 closes a frame,
    // so the snapshot reloads on the same edge and the next frame starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= 2'd0;
            snap      <= '0;
            snap_page <= PG_HM;
            seg       <= 8'hFF;
            an        <= 4'hF;
        end else if (scan_tick) begin
            idx <= idx + 2'd1;
            an  <= ~(4'b0001 << idx);
            seg <= {~slot_dp, seg7(slot_digit)};
            if (idx == 2'd3) begin
                snap      <= live;
                snap_page <= state;
            end
        end
    end

    always_comb begin
        slot_digit = 4'hF;
        slot_dp    = 1'b0;
        unique case (snap_page)
            PG_HM: slot_digit = (idx == 2'd0) ? snap.min0 : (idx == 2'd1) ? snap.min1 :
                                (idx == 2'd2) ? snap.hour0 : snap.hour1;
            PG_MS: slot_digit = (idx == 2'd0) ? snap.sec0 : (idx == 2'd1) ? snap.sec1 :
                                (idx == 2'd2) ? snap.min0 : snap.min1;
            PG_MD: slot_digit = (idx == 2'd0) ? snap.day0 : (idx == 2'd1) ? snap.day1 :
                                (idx == 2'd2) ? snap.month0 : snap.month1;
            PG_YR: slot_digit = (idx == 2'd0) ? snap.year0 : (idx == 2'd1) ? snap.year1 :
                                (idx == 2'd2) ? 4'd0 : 4'd2;
        endcase
        if (idx == 2'd2) begin
            unique case (snap_page)
                PG_HM:        slot_dp = ~snap.sec0[0];
                PG_MS, PG_MD: slot_dp = 1'b1;
                PG_YR:        slot_dp = 1'b0;
            endcase
        end
    end

    // sec_valid masks the first compare after reset, when sec0_d is still 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_d     <= 1'b0;
            sec0_d    <= 4'd0;
            sec_valid <= 1'b0;
        end else begin
            btn_d     <= page_btn;
            sec0_d    <= sec0;
            sec_valid <= 1'b1;
        end
    end

    assign btn_edge = page_btn && !btn_d;
    assign sec_tick = sec_valid && (sec0 != sec0_d);
    assign advance  = btn_edge || (auto_en && sec_tick && (hold_cnt == 4'(PAGE_HOLD - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PG_HM;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (advance) begin
            unique case (state)
                PG_HM: state_next = PG_MS;
                PG_MS: state_next = PG_MD;
                PG_MD: state_next = PG_YR;
                PG_YR: state_next = PG_HM;
            endcase
        end
    end

    always_comb begin
        page = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           hold_cnt <= 4'd0;
        else if (advance)  hold_cnt <= 4'd0;
        else if (!auto_en) hold_cnt <= 4'd0;
        else if (sec_tick) hold_cnt <= hold_cnt + 4'd1;
    end

endmodule
